// File: rtl/nn_ctrl_pkg.sv
// Shared control types for the training scheduler: FSM states,
// datapath mode encoding and the learning-rate decay helper.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRAIN   = 3'd1,
    ST_DRAIN_T = 3'd2,
    ST_DRAIN_I = 3'd3,
    ST_INFER   = 3'd4
  } state_t;

  localparam logic MODE_INFER = 1'b0;
  localparam logic MODE_TRAIN = 1'b1;

  // lr - lr/2^sh, floored at 1 so training never stalls on a zero rate
  function automatic logic [31:0] lr_decay(
    input logic [31:0] lr,
    input int          sh
  );
    logic [31:0] d;
    d = lr - (lr >> sh);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/inflight_counter.sv
// Up/down occupancy counter for transactions in the datapath pipe.
// Simultaneous inc/dec holds; dec while empty is ignored.
module inflight_counter
  import nn_ctrl_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inc,
  input  logic                       dec,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/weight_update_scheduler.sv
// Epoch/sample scheduler for a training datapath with in-flight limiting.
// Define WEIGHT_UPDATE_LR_DECAY_EN to decay the learning rate per epoch.
module weight_update_scheduler
  import nn_ctrl_pkg::*;
#(
  parameter int WD       = 8,
  parameter int NS       = 16,
  parameter int NE       = 4,
  parameter int DEPTH    = 3,
  parameter int LR_INIT  = 64,
  parameter int LR_SHIFT = 2
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iStart,
  input  logic                     iValid_AS,
  output logic                     oReady_AS,
  output logic                     oValid_BS,
  input  logic                     iReady_BS,
  input  logic                     iValid_R,
  input  logic                     iReady_R,
  output logic                     oMode,
  output logic [WD-1:0]            oLR,
  output logic [$clog2(NE+1)-1:0]  oEpoch,
  output logic                     oBusy,
  output logic                     oDone
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $clog2(NE + 1);
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   inflight;
  logic            full;
  logic            empty;
  logic [SW-1:0]   samp;
  logic [EW-1:0]   epoch_inc;
  logic            issue;
  logic            retire;
  logic            room;
  logic            drained;
  logic            samp_last;
  logic            epoch_last;
  logic            start_train;
  logic            pass;

  assign issue       = oValid_BS && iReady_BS;
  assign retire      = iValid_R && iReady_R;
  assign room        = !full || retire;
  // issue is blocked while draining, so one retire empties a count of 1
  assign drained     = empty || (inflight == CW'(1) && retire);
  assign samp_last   = (samp == SW'(NS - 1));
  assign epoch_inc   = oEpoch + 1'b1;
  assign epoch_last  = (epoch_inc == EW'(NE));
  assign start_train = (state == ST_IDLE && iStart) ||
                       (state == ST_DRAIN_I && drained);

  inflight_counter #(
    .DEPTH (DEPTH)
  ) u_inflight (
    .clk   (iCLK),
    .rst_n (iRST),
    .inc   (issue),
    .dec   (retire),
    .count (inflight),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (iStart) state_nxt = ST_TRAIN;
      ST_TRAIN:   if (issue && samp_last) state_nxt = ST_DRAIN_T;
      ST_DRAIN_T: if (drained)
                    state_nxt = epoch_last ? ST_INFER : ST_TRAIN;
      ST_INFER:   if (iStart) state_nxt = ST_DRAIN_I;
      ST_DRAIN_I: if (drained) state_nxt = ST_TRAIN;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pass      = (state == ST_TRAIN) || (state == ST_INFER);
    oValid_BS = pass && iValid_AS && room;
    oReady_AS = pass && iReady_BS && room;
    oMode     = (state == ST_TRAIN || state == ST_DRAIN_T) ?
                MODE_TRAIN : MODE_INFER;
    oBusy     = (state == ST_TRAIN) || (state == ST_DRAIN_T) ||
                (state == ST_DRAIN_I);
    oDone     = (state == ST_INFER);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      samp   <= '0;
      oEpoch <= '0;
      oLR    <= WD'(LR_INIT);
    end else if (start_train) begin
      samp   <= '0;
      oEpoch <= '0;
      oLR    <= WD'(LR_INIT);
    end else begin
      if (state == ST_TRAIN && issue) begin
        samp <= samp_last ? '0 : samp + 1'b1;
      end
      if (state == ST_DRAIN_T && drained) begin
        oEpoch <= epoch_inc;
`ifdef WEIGHT_UPDATE_LR_DECAY_EN
        oLR    <= WD'(lr_decay(32'(oLR), LR_SHIFT));
`else
        oLR    <= oLR;
`endif
      end
    end
  end

endmodule

// File: doc/weight_update_scheduler.md
WEIGHT_UPDATE_SCHEDULER -- requirements
Module: weight_update_scheduler

Interface
REQ-001 SHALL have parameter WD, default 8, meaning learning-rate word width.
REQ-002 SHALL have parameter NS, default 16, meaning samples per epoch.
REQ-003 SHALL have parameter NE, default 4, meaning training epochs.
REQ-004 SHALL have parameter DEPTH, default 3, meaning datapath pipeline depth, the in-flight limit.
REQ-005 SHALL have parameter LR_INIT, default 64, meaning initial learning rate.
REQ-006 SHALL have parameter LR_SHIFT, default 2, meaning decay shift.
REQ-007 SHALL have port iCLK, input, 1 bit: the single clock.
REQ-008 SHALL have port iRST, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port iStart, input, 1 bit: training start request.
REQ-010 SHALL have ports iValid_AS (input, 1) and oReady_AS (output, 1): upstream sample handshake.
REQ-011 SHALL have ports oValid_BS (output, 1) and iReady_BS (input, 1): issue handshake to the bias/weight datapath.
REQ-012 SHALL have ports iValid_R (input, 1) and iReady_R (input, 1): observed datapath output handshake.
REQ-013 SHALL have ports oMode (output, 1: 0 inference, 1 training) and oLR (output, WD): datapath controls.
REQ-014 SHALL have ports oEpoch (output, $clog2(NE+1)), oBusy (output, 1) and oDone (output, 1).

Function
REQ-015 SHALL implement FSM states IDLE, TRAIN, DRAIN_T, DRAIN_I and INFER.
REQ-016 SHALL make issue fire = oValid_BS&&iReady_BS and retire fire = iValid_R&&iReady_R.
REQ-017 SHALL keep inflight count, width $clog2(DEPTH+1): +1 on issue, -1 on retire, unchanged when both fire in the same cycle.
REQ-018 SHALL, in TRAIN and INFER, drive oValid_BS=iValid_AS&&(inflight<DEPTH||retire) and oReady_AS=iReady_BS&&(inflight<DEPTH||retire).
REQ-019 SHALL force oValid_BS=0 and oReady_AS=0 in IDLE, DRAIN_T and DRAIN_I.
REQ-020 SHALL go IDLE->TRAIN on iStart, clearing the sample counter and oEpoch and loading oLR=LR_INIT.
REQ-021 SHALL, in TRAIN, count issue fires, wrap the count to 0 on the NS-th fire, and go to DRAIN_T on that same edge.
REQ-022 SHALL, in DRAIN_T, leave when inflight==0 (retire this cycle included), increment oEpoch and update oLR per REQ-031.
REQ-023 SHALL, on leaving DRAIN_T, go to INFER if the new oEpoch==NE, else to TRAIN.
REQ-024 SHALL, in INFER, pass samples indefinitely with oDone=1; iStart goes to DRAIN_I.
REQ-025 SHALL, in DRAIN_I, go to TRAIN with the REQ-020 initialisation when inflight==0.
REQ-026 SHALL ignore iStart in TRAIN, DRAIN_T and DRAIN_I.
REQ-027 SHALL drive oMode=1 in TRAIN and DRAIN_T, and 0 otherwise; oMode changes only when inflight==0.
REQ-028 SHALL make oBusy=1 in TRAIN, DRAIN_T and DRAIN_I.
REQ-029 SHALL treat a retire fire with inflight==0 as a protocol error: count held at 0.

Reset
REQ-030 SHALL, while iRST=0, immediately force state IDLE, inflight=0, sample count=0, oEpoch=0, oLR=LR_INIT, oMode=0, oBusy=0, oDone=0, oValid_BS=0 and oReady_AS=0; reset mid-training discards in-flight accounting.

Configuration
REQ-031 SHALL, with macro WEIGHT_UPDATE_LR_DECAY_EN defined, set oLR=oLR-(oLR>>LR_SHIFT) at each epoch end, saturating at 1 (never 0).
REQ-032 SHALL, without WEIGHT_UPDATE_LR_DECAY_EN, hold oLR constant at LR_INIT.

Structure
REQ-033 SHALL place the state encoding constants and the mode encoding (MODE_INFER=0, MODE_TRAIN=1) in the shared package nn_ctrl_pkg.
REQ-034 SHALL implement the in-flight up/down counter as sub-module inflight_counter (parameter DEPTH; outputs count, full, empty).

Verification (NS=4, NE=2, DEPTH=3, LR_INIT=64, LR_SHIFT=2, decay enabled)
REQ-035 SHALL cover: iStart, then continuous valid with iReady_BS=1 and retire delayed 3 cycles -> 4 issues, oValid_BS=0 until 3 retires, oEpoch=1, oLR=48, re-enter TRAIN.
REQ-036 SHALL cover: run 2 epochs -> INFER, oMode=0, oDone=1, oLR=36, oBusy=0; samples pass.
REQ-037 SHALL cover: retire held low, 3 issues -> oReady_AS=0 at inflight=3; a same-cycle issue and retire keep the count at 3.
REQ-038 SHALL cover: iStart in INFER with 2 in flight -> DRAIN_I, oMode stays 0 until both retire, then TRAIN, oLR=64, oEpoch=0.
REQ-039 SHALL cover: iRST=0 asserted mid-TRAIN with 2 in flight -> all outputs at reset values asynchronously; iStart re-arms cleanly.
REQ-040 SHALL cover: LR_INIT=2 over 3 epochs -> oLR 2, 2, 2 (2-0), with the saturation floor at 1 checked using LR_SHIFT=0; without the macro, oLR is constant at 64.
